// File: rtl/hazard_scoreboard.sv
// Parametrised pipeline hazard scoreboard: tracks in-flight register writers per stage,
// resolves EX operand forwarding one cycle ahead and raises load-use stalls.
module hazard_scoreboard #(
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 3,
  parameter int NREG       = 32,
  parameter int SELW       = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mem_ready,
  input  logic                        flush,
  input  logic                        id_valid,
  input  logic [$clog2(NREG)-1:0]     id_rs1,
  input  logic [$clog2(NREG)-1:0]     id_rs2,
  input  logic                        id_use1,
  input  logic                        id_use2,
  input  logic [$clog2(NREG)-1:0]     id_rd,
  input  logic                        id_we,
  input  logic                        id_load,
  output logic                        stall,
  output logic [SELW-1:0]             fwd_sel1,
  output logic [SELW-1:0]             fwd_sel2,
  output logic [$clog2(DEPTH+1)-1:0]  inflight
);

  localparam int RW = $clog2(NREG);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rd;
    logic          we;
    logic          load;
  } entry_t;

  typedef struct packed {
    logic            hit;
    logic [SELW-1:0] sel;
    logic            load;
  } match_t;

  // Stages 1..DEPTH-1 are searchable; the WB stage only contributes to the in-flight count,
  // because the write-through regfile already serves decode from it.
  typedef entry_t [DEPTH-1:1] pipe_t;

  pipe_t           ent_q, ent_d;
  logic            wb_wr_q, wb_wr_d;
  logic [SELW-1:0] fwd1_q, fwd1_d, fwd2_q, fwd2_d;
  match_t          m1, m2;
  logic            issue;
  logic [CW-1:0]   cnt;

  // Youngest writer wins: the scan runs oldest to youngest so the last hit overrides.
  function automatic match_t find_match(input pipe_t ents, input logic [RW-1:0] rs,
                                        input logic use_s);
    match_t m;
    m = '0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (use_s && rs != '0 && ents[k].valid && ents[k].we && ents[k].rd == rs) begin
        m.hit  = 1'b1;
        m.sel  = SELW'(k + 1);
        m.load = ents[k].load;
      end
    end
    return m;
  endfunction

  // A load forwarded from stage sel is usable only once sel has reached the load bus.
  function automatic logic load_hazard(input match_t m);
    return m.hit && m.load && (int'(m.sel) < LOAD_STAGE);
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ent_d   = '0;
    m1      = find_match(ent_q, id_rs1, id_use1);
    m2      = find_match(ent_q, id_rs2, id_use2);
    stall   = id_valid && !flush && (load_hazard(m1) || load_hazard(m2));
    issue   = id_valid && !stall && !flush;

    for (int k = DEPTH - 1; k >= 2; k--) begin
      ent_d[k] = ent_q[k-1];
    end
    if (issue) begin
      ent_d[1] = '{valid: 1'b1, rd: id_rd, we: id_we, load: id_load};
    end
    wb_wr_d = ent_q[DEPTH-1].valid && ent_q[DEPTH-1].we;

    fwd1_d = issue ? m1.sel : '0;
    fwd2_d = issue ? m2.sel : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the whole scoreboard is reset, not just the valid bits, so rd/load never
    // carry X into the comparators; it is a handful of flops, not a RAM.
    if (reset) begin
      ent_q   <= '0;
      wb_wr_q <= 1'b0;
      fwd1_q  <= '0;
      fwd2_q  <= '0;
    end else if (mem_ready) begin
      // NOTE: state registers use non-blocking assignment so every stage shifts from
      // the pre-edge values in the same cycle.
      ent_q   <= ent_d;
      wb_wr_q <= wb_wr_d;
      fwd1_q  <= fwd1_d;
      fwd2_q  <= fwd2_d;
    end
  end

  always_comb begin
    cnt = CW'(wb_wr_q);
    for (int k = 1; k <= DEPTH - 1; k++) begin
      cnt = cnt + CW'(ent_q[k].valid & ent_q[k].we);
    end
  end

  assign fwd_sel1 = fwd1_q;
  assign fwd_sel2 = fwd2_q;
  assign inflight = cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: two configurations (DEPTH/LOAD_STAGE 3/3 and 4/4) share one stimulus
// stream; a stage-array reference model predicts stall, selects and in-flight count.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mem_ready = 1'b1;
  logic       flush = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_use1 = 1'b0, id_use2 = 1'b0, id_we = 1'b0, id_load = 1'b0;

  logic       stall_a, stall_b;
  logic [1:0] f1_a, f2_a, inf_a;
  logic [2:0] f1_b, f2_b, inf_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.DEPTH(3), .LOAD_STAGE(3), .NREG(32)) dut_a (
    .clk(clk), .reset(reset), .mem_ready(mem_ready), .flush(flush), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .id_rd(id_rd), .id_we(id_we), .id_load(id_load),
    .stall(stall_a), .fwd_sel1(f1_a), .fwd_sel2(f2_a), .inflight(inf_a)
  );

  hazard_scoreboard #(.DEPTH(4), .LOAD_STAGE(4), .NREG(32)) dut_b (
    .clk(clk), .reset(reset), .mem_ready(mem_ready), .flush(flush), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .id_rd(id_rd), .id_we(id_we), .id_load(id_load),
    .stall(stall_b), .fwd_sel1(f1_b), .fwd_sel2(f2_b), .inflight(inf_b)
  );

  // ---------------- reference model: instruction records per pipeline stage ----------------
  int depth  [2] = '{3, 4};
  int lstage [2] = '{3, 4};
  bit mv  [2][1:8];
  int mrd [2][1:8];
  bit mwe [2][1:8];
  bit mld [2][1:8];
  int mf1 [2];
  int mf2 [2];

  typedef struct {
    int step;
    int st[2];
    int f1[2];
    int f2[2];
    int inf[2];
  } exp_t;

  exp_t sb[$];
  int   step_no = 0;

  function automatic void model_clear();
    for (int m = 0; m < 2; m++) begin
      for (int k = 1; k <= 8; k++) begin
        mv[m][k] = 0; mrd[m][k] = 0; mwe[m][k] = 0; mld[m][k] = 0;
      end
      mf1[m] = 0; mf2[m] = 0;
    end
  endfunction

  // Stage the consumer's producer will occupy once the consumer is in EX (0 = regfile).
  function automatic int producer_stage(int m, int rs, bit u, output bit is_load);
    int found = 0;
    is_load = 0;
    if (u && rs != 0) begin
      for (int k = 1; k < depth[m]; k++) begin
        if (found == 0 && mv[m][k] && mwe[m][k] && mrd[m][k] == rs) begin
          found   = k + 1;
          is_load = mld[m][k];
        end
      end
    end
    return found;
  endfunction

  function automatic int model_count(int m);
    int n = 0;
    for (int k = 1; k <= depth[m]; k++) n += (mv[m][k] && mwe[m][k]) ? 1 : 0;
    return n;
  endfunction

  task automatic check(input string name, input int act, input int exp, input int step);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, exp);
    end
  endtask

  // Drive one cycle of inputs; predict outputs seen before the next edge; advance model.
  task automatic drive(input bit v, input int rd, input bit we, input bit ld,
                       input int rs1, input bit u1, input int rs2, input bit u2,
                       input bit mr, input bit fl, input bit rst, output bit any_stall);
    exp_t e;
    int   p1, p2;
    bit   l1, l2;
    @(posedge clk);
    #1;
    reset = rst; mem_ready = mr; flush = fl; id_valid = v;
    id_rd = 5'(rd); id_we = we; id_load = ld;
    id_rs1 = 5'(rs1); id_use1 = u1; id_rs2 = 5'(rs2); id_use2 = u2;
    if (rst) model_clear();
    step_no++;
    e.step = step_no;
    any_stall = 0;
    for (int m = 0; m < 2; m++) begin
      bit st, go;
      p1 = producer_stage(m, rs1, u1, l1);
      p2 = producer_stage(m, rs2, u2, l2);
      st = v && !fl && ((p1 != 0 && l1 && p1 < lstage[m]) || (p2 != 0 && l2 && p2 < lstage[m]));
      e.st[m]  = int'(st);
      e.f1[m]  = mf1[m];
      e.f2[m]  = mf2[m];
      e.inf[m] = model_count(m);
      any_stall |= st;
      if (!rst && mr) begin
        go = v && !st && !fl;
        for (int k = depth[m]; k >= 2; k--) begin
          mv[m][k] = mv[m][k-1]; mrd[m][k] = mrd[m][k-1];
          mwe[m][k] = mwe[m][k-1]; mld[m][k] = mld[m][k-1];
        end
        mv[m][1] = go; mrd[m][1] = rd; mwe[m][1] = go && we; mld[m][1] = go && ld;
        mf1[m] = go ? p1 : 0;
        mf2[m] = go ? p2 : 0;
      end
    end
    sb.push_back(e);
  endtask

  // Present an instruction, holding it in decode while either configuration stalls.
  task automatic issue(input int rd, input bit we, input bit ld,
                       input int rs1, input bit u1, input int rs2, input bit u2);
    bit s;
    for (int i = 0; i < 8; i++) begin
      drive(1, rd, we, ld, rs1, u1, rs2, u2, 1, 0, 0, s);
      if (!s) break;
    end
  endtask

  task automatic idle(input int n);
    bit s;
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, s);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("stall_a",    int'(stall_a), e.st[0],  e.step);
        check("fwd_sel1_a", int'(f1_a),    e.f1[0],  e.step);
        check("fwd_sel2_a", int'(f2_a),    e.f2[0],  e.step);
        check("inflight_a", int'(inf_a),   e.inf[0], e.step);
        check("stall_b",    int'(stall_b), e.st[1],  e.step);
        check("fwd_sel1_b", int'(f1_b),    e.f1[1],  e.step);
        check("fwd_sel2_b", int'(f2_b),    e.f2[1],  e.step);
        check("inflight_b", int'(inf_b),   e.inf[1], e.step);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit s;
    model_clear();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, s);
    drive(1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 1, s);
    idle(1);

    // ALU chain: x5 then three readers of x5
    issue(5, 1, 0, 1, 1, 2, 1);
    issue(6, 1, 0, 5, 1, 5, 1);
    issue(9, 1, 0, 5, 1, 0, 0);
    issue(10, 1, 0, 5, 1, 5, 1);
    idle(4);

    // Load-use: lw x7; add x8,x7,x1
    issue(7, 1, 1, 2, 1, 0, 0);
    issue(8, 1, 0, 7, 1, 1, 1);
    idle(5);

    // Youngest wins, then writes to x0
    issue(3, 1, 0, 0, 0, 0, 0);
    issue(3, 1, 0, 0, 0, 0, 0);
    issue(11, 1, 0, 3, 1, 3, 1);
    issue(0, 1, 1, 0, 0, 0, 0);
    issue(0, 1, 0, 0, 0, 0, 0);
    issue(12, 1, 0, 0, 1, 0, 1);
    idle(4);

    // Freeze for 5 cycles with flush pulsing and a live decode
    issue(4, 1, 1, 0, 0, 0, 0);
    issue(13, 1, 0, 6, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      drive(1, 14, 1, 0, 4, 1, 13, 1, 0, bit'(i % 2), 0, s);
    issue(14, 1, 0, 4, 1, 13, 1);
    issue(15, 1, 0, 13, 1, 4, 1);
    idle(4);

    // Flush during a load-use stall
    issue(7, 1, 1, 0, 0, 0, 0);
    drive(1, 8, 1, 0, 7, 1, 7, 1, 1, 1, 0, s);
    idle(5);

    // Async reset with three writers in flight, then a dependent pair from empty
    issue(11, 1, 0, 0, 0, 0, 0);
    issue(12, 1, 0, 0, 0, 0, 0);
    issue(13, 1, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, s);
    issue(20, 1, 0, 0, 0, 0, 0);
    issue(21, 1, 0, 20, 1, 20, 1);
    idle(4);

    // Randomised traffic over a small register window to provoke hazards
    for (int i = 0; i < 600; i++) begin
      drive(bit'($urandom_range(0, 9) < 8), int'($urandom_range(0, 7)),
            bit'($urandom_range(0, 4) != 0), bit'($urandom_range(0, 2) == 0),
            int'($urandom_range(0, 7)), bit'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 7)), bit'($urandom_range(0, 3) != 0),
            bit'($urandom_range(0, 6) != 0), bit'($urandom_range(0, 9) == 0),
            bit'($urandom_range(0, 99) == 0), s);
    end
    idle(2);

    @(negedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0, step_no);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
